phrase_vram_writer: RTL
=======================

PHRASE_VRAM_WRITER -- requirements
Module: phrase_vram_writer

Interface
REQ-001 Parameters: ROW_WORDS default 40 (VRAM words per text row); NUM_ROWS default 30; ADDR_W default 11 (VRAM word address width).
REQ-002 Ports: clk in 1, system clock; reset in 1, synchronous active-high; one clock, all logic on posedge clk.
REQ-003 req_valid in 1 / req_ready out 1: request handshake; transfer on valid&&ready.
REQ-004 req_phrase in 16 {note[15:8], volume[7:2], instrument[1:0]}; req_row in 5; req_col in 6 (first word column); req_cursor_en in 1; req_cursor_field in 2; req_fgd in 4; req_bkg in 4.
REQ-005 phrase_out out 16, sel_type out 2: drive the pixel-code converter; pix_codes in 14 = its registered output {left char[13:7], right char[6:0]}.
REQ-006 vram_we out 1, vram_addr out ADDR_W, vram_wdata out 32, vram_grant in 1: write port; a write completes on vram_we&&vram_grant.
REQ-007 busy out 1 (state != IDLE); done out 1 (one-cycle completion pulse); err out 1 (valid with done).

Function
REQ-008 FSM states IDLE, CONV, WRITE; req_ready = (state==IDLE) && !reset.
REQ-009 On accept: latch all req_* fields; phrase_out <= req_phrase; field counter <= 0; go to CONV.
REQ-010 CONV (1 cycle): sel_type = field; pix_codes is sampled in the following WRITE cycle (converter latency 1); go to WRITE.
REQ-011 WRITE: vram_we=1; vram_addr = row*ROW_WORDS + col + field, truncated to ADDR_W (wrap, no clamp); all write outputs held stable until vram_grant.
REQ-012 vram_wdata = {IV, pix_codes[6:0], fgd, bkg, IV, pix_codes[13:7], fgd, bkg}; IV = cursor_en && (cursor_field==field); left char in bits 14:8.
REQ-013 WRITE with grant: if field==3 go to IDLE and pulse done; else field+1, go to CONV; without grant stay in WRITE.
REQ-014 Field order fixed: 0 note letter/sharp, 1 octave, 2 volume, 3 instrument -> 4 consecutive word addresses.
REQ-015 Latency with grant tied high: accept at edge k; writes in cycles k+2, k+4, k+6, k+8; done in cycle k+9; new request accepted in the done cycle.
REQ-016 req_row >= NUM_ROWS: request accepted; no VRAM writes; FSM returns to IDLE next cycle with done=1, err=1.
REQ-017 req_* changes while busy are ignored; latched copy is used.
REQ-018 0x00 character codes are written unchanged (blank cell).

Reset
REQ-019 While reset is high: state=IDLE, field=0, req_ready=0, vram_we=0, vram_addr=0, vram_wdata=0, sel_type=0, phrase_out=0, busy=0, done=0, err=0.
REQ-020 Reset mid-sequence aborts at the next edge with no further writes; partially written words are left as written.

Structure
REQ-021 Shared package holds the FSM state enum, field encodings (FLD_NOTE..FLD_INST), VRAM word field positions and ROW_WORDS/NUM_ROWS defaults.
REQ-022 Converter is not embedded: the existing pixel-code converter is instantiated beside this block at the next level up; a thin address-generator sub-module, vram_addr_gen (row*ROW_WORDS+col+field), is natural.

Verification
REQ-023 phrase 0x3DF3, row 2, col 10, fgd F, bkg 0, no cursor, grant=1 -> writes 90:0x23F043F0, 91:0x35F000F0, 92:0x30F036F0, 93:0x33F000F0; done at k+9.
REQ-024 Same request, cursor_en=1, field 0 -> addr 90 = 0xA3F0C3F0; addrs 91-93 unchanged from REQ-023.
REQ-025 Grant low for 3 cycles on the 2nd write -> addr/wdata held stable; exactly 4 writes; done delayed by 3 cycles.
REQ-026 req_row=30 -> no vram_we; done=err=1 one cycle after accept.
REQ-027 Reset asserted during the 3rd WRITE -> vram_we=0 next cycle; no 4th write; req_ready=1 after reset deasserts.
REQ-028 Back-to-back requests, valid held high -> 2nd accepted in the 1st request's done cycle; 8 writes total, no idle gap.

Source files
------------

// File: rtl/phrase_vram_writer_pkg.sv
// phrase_vram_writer_pkg: shared FSM state, field encodings, VRAM word layout and geometry defaults
package phrase_vram_writer_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_WRITE} state_t;
  typedef enum logic [1:0] {FLD_NOTE, FLD_OCT, FLD_VOL, FLD_INST} field_t;
  localparam int ROW_WORDS_DEF = 40;
  localparam int NUM_ROWS_DEF = 30;
  localparam int ADDR_W_DEF = 11;
  localparam int HALF_W = 16;
  localparam int IV_BIT = 15;
  localparam int CHR_LSB = 8;
  localparam int FGD_LSB = 4;
  localparam int BKG_LSB = 0;
  function automatic logic [HALF_W-1:0] pack_half(logic iv, logic [6:0] chr, logic [3:0] fgd, logic [3:0] bkg);
    logic [HALF_W-1:0] h;
    h = '0;
    h[IV_BIT] = iv;
    h[CHR_LSB+:7] = chr;
    h[FGD_LSB+:4] = fgd;
    h[BKG_LSB+:4] = bkg;
    return h;
  endfunction
  function automatic logic [2*HALF_W-1:0] pack_word(logic iv, logic [13:0] pix, logic [3:0] fgd, logic [3:0] bkg);
    return {pack_half(iv, pix[6:0], fgd, bkg), pack_half(iv, pix[13:7], fgd, bkg)};
  endfunction
endpackage

// File: rtl/phrase_vram_writer_addr_gen.sv
// vram_addr_gen: word address row*ROW_WORDS + col + field, wrapped to ADDR_W bits
module vram_addr_gen
  import phrase_vram_writer_pkg::*;
#(
  parameter int ROW_WORDS = ROW_WORDS_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [4:0]        row,
  input  logic [5:0]        col,
  input  logic [1:0]        field,
  output logic [ADDR_W-1:0] addr
);
  always_comb addr = ADDR_W'(int'(row) * ROW_WORDS + int'(col) + int'(field));
endmodule

// File: rtl/phrase_vram_writer.sv
// phrase_vram_writer: converts one phrase into four VRAM text words via an external pixel-code converter
module phrase_vram_writer
  import phrase_vram_writer_pkg::*;
#(
  parameter int ROW_WORDS = ROW_WORDS_DEF,
  parameter int NUM_ROWS = NUM_ROWS_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [15:0]       req_phrase,
  input  logic [4:0]        req_row,
  input  logic [5:0]        req_col,
  input  logic              req_cursor_en,
  input  logic [1:0]        req_cursor_field,
  input  logic [3:0]        req_fgd,
  input  logic [3:0]        req_bkg,
  output logic [15:0]       phrase_out,
  output logic [1:0]        sel_type,
  input  logic [13:0]       pix_codes,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [31:0]       vram_wdata,
  input  logic              vram_grant,
  output logic              busy,
  output logic              done,
  output logic              err
);
  state_t state;
  field_t field;
  logic [4:0] row_q;
  logic [5:0] col_q;
  logic cen_q;
  logic [1:0] cf_q;
  logic [3:0] fgd_q, bkg_q;
  logic done_q, err_q, iv;
  logic [ADDR_W-1:0] addr;
  vram_addr_gen #(.ROW_WORDS(ROW_WORDS), .ADDR_W(ADDR_W)) u_addr (
    .row(row_q), .col(col_q), .field(field), .addr(addr)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      field <= FLD_NOTE;
      phrase_out <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q <= 1'b0;
      case (state)
        ST_IDLE: if (req_valid) begin
          phrase_out <= req_phrase;
          row_q <= req_row;
          col_q <= req_col;
          cen_q <= req_cursor_en;
          cf_q <= req_cursor_field;
          fgd_q <= req_fgd;
          bkg_q <= req_bkg;
          field <= FLD_NOTE;
          // off-screen rows are acknowledged with an error instead of writing
          if (int'(req_row) >= NUM_ROWS) begin
            done_q <= 1'b1;
            err_q <= 1'b1;
          end else state <= ST_CONV;
        end
        ST_CONV: state <= ST_WRITE;
        ST_WRITE: if (vram_grant) begin
          if (field == FLD_INST) begin
            state <= ST_IDLE;
            done_q <= 1'b1;
          end else begin
            field <= field_t'(field + 2'd1);
            state <= ST_CONV;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
  // decoded outputs are forced quiet combinationally while reset is held
  always_comb begin
    iv = cen_q && (cf_q == field);
    req_ready = (state == ST_IDLE) && !reset;
    busy = (state != ST_IDLE) && !reset;
    vram_we = (state == ST_WRITE) && !reset;
    vram_addr = vram_we ? addr : '0;
    vram_wdata = vram_we ? pack_word(iv, pix_codes, fgd_q, bkg_q) : '0;
    sel_type = reset ? 2'd0 : field;
    done = done_q && !reset;
    err = err_q && !reset;
  end
endmodule
